// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared constants and state encoding for the fabric configuration loader
package fpga_cfg_pkg;

    localparam logic [15:0] CFG_MAGIC = 16'hFC0F;

    localparam int MAGIC_MSB = 31;
    localparam int MAGIC_LSB = 16;
    localparam int COUNT_MSB = 7;
    localparam int COUNT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECK,
        COMMIT
    } cfg_state_t;

endpackage

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - streamed bitstream loader with header/checksum validation and atomic commit
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_LUT = 8,
    parameter int LUT_K   = 4,
    parameter int NUM_SB  = 5,
    parameter int SB_BITS = 16,
    parameter int WORD_W  = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [WORD_W-1:0]                   cfg_data,
    output logic [NUM_LUT*(2**LUT_K + 1)-1:0]   lut_cfg,
    output logic [NUM_SB*SB_BITS-1:0]           sb_cfg,
    output logic                                cfg_locked,
    output logic                                busy,
    output logic                                done,
    output logic                                error
);

    localparam int LUT_BITS = 2**LUT_K + 1;
    localparam int NUM_CFG  = NUM_LUT + NUM_SB;
    localparam int CNT_W    = $clog2(NUM_CFG + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_CFG - 1);
    localparam logic [7:0]       HDR_COUNT = 8'(NUM_CFG);

    cfg_state_t        state;
    cfg_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] csum;
    logic              hdr_ok;
    logic              clear_load;
    logic              load_word;
    logic              set_error;
    logic              commit;

    assign hdr_ok = (cfg_data[MAGIC_MSB:MAGIC_LSB] == CFG_MAGIC) &&
                    (cfg_data[COUNT_MSB:COUNT_LSB] == HDR_COUNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        clear_load = 1'b0;
        load_word  = 1'b0;
        set_error  = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clear_load = 1'b1;
                    state_nxt  = HEADER;
                end
            end
            HEADER: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (hdr_ok) begin
                        state_nxt = PAYLOAD;
                    end else begin
                        set_error = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    load_word = 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_data == csum) begin
                        state_nxt = COMMIT;
                    end else begin
                        set_error = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            COMMIT: begin
                done      = 1'b1;
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            csum       <= '0;
            error      <= 1'b0;
            cfg_locked <= 1'b0;
        end else begin
            if (clear_load) begin
                cnt   <= '0;
                csum  <= '0;
                error <= 1'b0;
            end
            if (set_error) begin
                error <= 1'b1;
            end
            if (load_word) begin
                cnt  <= cnt + CNT_W'(1);
                csum <= csum ^ cfg_data;
            end
            if (commit) begin
                cfg_locked <= 1'b1;
            end
        end
    end

    // Shadows fill word by word; active copies only move on commit, so the fabric never sees a partial load.
    for (genvar i = 0; i < NUM_LUT; i++) begin : g_lut
        logic [LUT_BITS-1:0] shadow;
        logic [LUT_BITS-1:0] active;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                shadow <= '0;
                active <= '0;
            end else begin
                if (load_word && (cnt == CNT_W'(i))) begin
                    shadow <= cfg_data[LUT_BITS-1:0];
                end
                if (commit) begin
                    active <= shadow;
                end
            end
        end
        assign lut_cfg[i*LUT_BITS +: LUT_BITS] = active;
    end

    for (genvar j = 0; j < NUM_SB; j++) begin : g_sb
        logic [SB_BITS-1:0] shadow;
        logic [SB_BITS-1:0] active;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                shadow <= '0;
                active <= '0;
            end else begin
                if (load_word && (cnt == CNT_W'(NUM_LUT + j))) begin
                    shadow <= cfg_data[SB_BITS-1:0];
                end
                if (commit) begin
                    active <= shadow;
                end
            end
        end
        assign sb_cfg[j*SB_BITS +: SB_BITS] = active;
    end

endmodule
